// File: rtl/nbit_piso_tx.sv
// rtl/nbit_piso_tx.sv - N-bit parallel-in/serial-out transmitter with load and serial valid/ready handshakes
module nbit_piso_tx #(
    parameter int N         = 6,
    parameter int MSB_FIRST = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] D,
    input  logic         load_valid,
    output logic         load_ready,
    output logic         sout,
    output logic         sout_valid,
    input  logic         sout_ready,
    output logic         sout_first,
    output logic         sout_last
);

    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic out_bit;
    logic load_fire;
    logic last_fire;

    // Serial outputs are decoded from registers only; load_ready alone sees sout_ready
    always_comb begin
        out_bit    = (MSB_FIRST != 0) ? shreg_q[N-1] : shreg_q[0];
        sout_valid = (state_q == SHIFT);
        sout       = sout_valid ? out_bit : 1'b0;
        sout_first = sout_valid && (cnt_q == '0);
        sout_last  = sout_valid && (cnt_q == LAST_CNT);
        last_fire  = sout_last && sout_ready;
        load_ready = (state_q == IDLE) || last_fire;
        load_fire  = load_valid && load_ready;
    end

    // Next-state: a load (from idle or on the final bit) wins; otherwise shift or go idle on consume
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load_fire) begin
            shreg_d = D;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if ((state_q == SHIFT) && sout_ready) begin
            if (sout_last) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                if (MSB_FIRST != 0) begin
                    shreg_d = {shreg_q[N-2:0], 1'b0};
                end else begin
                    shreg_d = {1'b0, shreg_q[N-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State, shift register and bit counter; reset aborts any frame in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_nbit_piso_tx.sv
// tb/tb_nbit_piso_tx.sv - directed table-driven bench for nbit_piso_tx (N=6, both bit orders)
module tb_nbit_piso_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] d = '0;
    logic       load_valid = 1'b0;
    logic       sout_ready = 1'b1;

    logic lr_m, s_m, v_m, f_m, l_m;
    logic lr_l, s_l, v_l, f_l, l_l;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nbit_piso_tx #(.N(6), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .D(d), .load_valid(load_valid), .load_ready(lr_m),
        .sout(s_m), .sout_valid(v_m), .sout_ready(sout_ready),
        .sout_first(f_m), .sout_last(l_m)
    );

    nbit_piso_tx #(.N(6), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .D(d), .load_valid(load_valid), .load_ready(lr_l),
        .sout(s_l), .sout_valid(v_l), .sout_ready(sout_ready),
        .sout_first(f_l), .sout_last(l_l)
    );

    typedef struct {
        logic       lv;
        logic [5:0] dv;
        logic       sr;
        logic       ev;
        logic       es_m;
        logic       es_l;
        logic       ef;
        logic       el;
        logic       elr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic lv, input logic [5:0] dv, input logic sr,
                       input logic ev, input logic es_m, input logic es_l,
                       input logic ef, input logic el, input logic elr);
        vec_t v;
        v.lv = lv; v.dv = dv; v.sr = sr; v.ev = ev; v.es_m = es_m; v.es_l = es_l;
        v.ef = ef; v.el = el; v.elr = elr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic ev, input logic es_m, input logic es_l,
                           input logic ef, input logic el, input logic elr);
        chk("valid_msb", idx, v_m, ev);
        chk("valid_lsb", idx, v_l, ev);
        chk("sout_msb", idx, s_m, es_m);
        chk("sout_lsb", idx, s_l, es_l);
        chk("first_msb", idx, f_m, ef);
        chk("first_lsb", idx, f_l, ef);
        chk("last_msb", idx, l_m, el);
        chk("last_lsb", idx, l_l, el);
        chk("load_ready_msb", idx, lr_m, elr);
        chk("load_ready_lsb", idx, lr_l, elr);
    endtask

    task automatic frame(input logic [5:0] w, input logic [5:0] next_d, input logic next_lv);
        for (int i = 0; i < 6; i++) begin
            add((i == 5) ? next_lv : 1'b0, (i == 5) ? next_d : 6'd0, 1'b1,
                1'b1, w[5-i], w[i], i == 0, i == 5, i == 5);
        end
    endtask

    initial begin
        // idle, single word 101101
        add(0, 6'd0, 1, 0, 0, 0, 0, 0, 1);
        add(1, 6'b101101, 1, 0, 0, 0, 0, 0, 1);
        frame(6'b101101, 6'd0, 0);
        add(0, 6'd0, 1, 0, 0, 0, 0, 0, 1);
        // back-to-back 111000 then 000111, next word waiting while busy
        add(1, 6'b111000, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++)
            add(1, 6'b000111, 1, 1, i < 3, i >= 3, i == 0, i == 5, i == 5);
        frame(6'b000111, 6'd0, 0);
        add(0, 6'd0, 1, 0, 0, 0, 0, 0, 1);
        // backpressure in bit cycles 3 and 4 of 101101
        add(1, 6'b101101, 1, 0, 0, 0, 0, 0, 1);
        add(0, 6'd0, 1, 1, 1, 1, 1, 0, 0);
        add(0, 6'd0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 6'd0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 6'd0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 6'd0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 6'd0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 6'd0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 6'd0, 1, 1, 1, 1, 0, 1, 1);
        // stall on the last bit with the next word pending, then gapless reload
        add(1, 6'b110010, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            add(0, 6'd0, 1, 1, w110010_m(i), w110010_l(i), i == 0, 0, 0);
        add(1, 6'b001101, 0, 1, 0, 1, 0, 1, 0);
        add(1, 6'b001101, 1, 1, 0, 1, 0, 1, 1);
        frame(6'b001101, 6'd0, 0);
        add(0, 6'd0, 1, 0, 0, 0, 0, 0, 1);

        // reset held from time zero
        #3;
        chk_all(-1, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all(-2, 0, 0, 0, 0, 0, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            load_valid = vecs[i].lv;
            d          = vecs[i].dv;
            sout_ready = vecs[i].sr;
            #1;
            chk_all(i, vecs[i].ev, vecs[i].es_m, vecs[i].es_l, vecs[i].ef, vecs[i].el, vecs[i].elr);
        end

        // load-while-busy ignored, then async reset mid-frame
        @(negedge clk);
        load_valid = 1; d = 6'b101101; sout_ready = 1;
        #1; chk_all(100, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        load_valid = 0; d = 6'd0;
        #1; chk_all(101, 1, 1, 1, 1, 0, 0);
        @(negedge clk);
        load_valid = 1; d = 6'b010101;
        #1; chk_all(102, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        load_valid = 0; d = 6'd0;
        #1; chk_all(103, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        #1; chk_all(104, 1, 1, 1, 0, 0, 0);
        #1; rst = 1'b1;
        #1; chk_all(105, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1; chk_all(106, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1; chk_all(107 + i, 0, 0, 0, 0, 0, 1);
        end
        @(negedge clk);
        load_valid = 1; d = 6'b110010;
        #1; chk_all(110, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        load_valid = 0; d = 6'd0;
        #1; chk_all(111, 1, 1, 0, 1, 0, 0);
        @(negedge clk);
        #1; chk_all(112, 1, 1, 1, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic w110010_m(input int i);
        logic [5:0] w;
        w = 6'b110010;
        return w[5-i];
    endfunction

    function automatic logic w110010_l(input int i);
        logic [5:0] w;
        w = 6'b110010;
        return w[i];
    endfunction

endmodule

// File: doc/nbit_piso_tx.md
# nbit_piso_tx

Parameterised N-bit parallel-in/serial-out transmitter. Accepts a parallel word through a valid/ready load handshake and shifts it out one bit per accepted cycle on a serial valid/ready stream, with first/last-bit markers. It is the transmit end of the serial path whose receive end captures N-bit words into the datapath's N-bit registers. Gapless back-to-back transmission is supported.

## Interface

- N, 6, word width in bits; N >= 2
- MSB_FIRST, 1, 1: bit N-1 is sent first; 0: bit 0 is sent first
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- D  input  N  parallel word to transmit
- load_valid  input  1  D is valid this cycle
- load_ready  output  1  transmitter can accept D this cycle
- sout  output  1  current serial bit
- sout_valid  output  1  sout holds a valid bit
- sout_ready  input  1  downstream consumes sout this cycle
- sout_first  output  1  sout is bit 0 of the frame (first transmitted)
- sout_last  output  1  sout is bit N-1 of the frame (last transmitted)

## Operation

- Registers: shreg[N-1:0], cnt[$clog2(N)-1:0], state in {IDLE, SHIFT}.
- Reset (async, rst=1): state=IDLE, shreg=0, cnt=0. Outputs during and after reset: sout=0, sout_valid=0, sout_first=0, sout_last=0, load_ready=1.
- Outputs are decoded from registers only, except load_ready:
  - sout_valid = (state==SHIFT)
  - sout = MSB_FIRST ? shreg[N-1] : shreg[0], forced to 0 in IDLE
  - sout_first = sout_valid && cnt==0
  - sout_last = sout_valid && cnt==N-1
  - load_ready = (state==IDLE) || (sout_last && sout_ready). This is the only combinational input-to-output path.
- Load: when load_valid && load_ready at a rising edge, shreg<=D, cnt<=0, state<=SHIFT.
- Shift: in SHIFT, when sout_ready=1 and not sout_last, shreg shifts toward the output end (left for MSB_FIRST, right otherwise; zero fill) and cnt<=cnt+1.
- Stall: in SHIFT, when sout_ready=0, shreg and cnt hold, and sout and its markers stay stable. sout_valid never drops mid-frame except on reset.
- Last bit consumed (sout_last && sout_ready):
  - With load_valid=1: reload from D. cnt wraps to 0 and state stays SHIFT, giving no idle cycle.
  - With load_valid=0: state<=IDLE, cnt<=0.
- load_valid while load_ready=0 is ignored. The upstream holds D and load_valid until accepted.
- Reset mid-frame aborts the frame immediately. The partial frame is lost and no sout_last is emitted.

## Timing

- Load accepted at edge k: the first bit is on sout (sout_valid=1, sout_first=1) in the cycle after edge k.
- With sout_ready held at 1, bit i is presented in cycle k+1+i, and sout_last is in cycle k+N.
- Each stall cycle (sout_ready=0) delays all remaining bits by one cycle.
- Throughput: one bit per cycle. Continuous words give N*W consecutive valid cycles for W words.
- The combinational sout_ready -> load_ready path must meet a single-cycle path.

## Test plan

- Reset: assert rst asynchronously mid-cycle -> sout_valid, sout, sout_first and sout_last go 0 immediately and load_ready=1; after release, all stay idle until the first load.
- Single word, N=6, MSB_FIRST=1, D=6'b101101, sout_ready=1 -> sout=1,0,1,1,0,1 in cycles 1..6 after the load edge. sout_first only in cycle 1, sout_last only in cycle 6, then sout_valid=0.
- MSB_FIRST=0, D=6'b101101 -> sout=1,0,1,1,0,1 read as bit0..bit5 (1,0,1,1,0,1); markers as above.
- Back-to-back: 6'b111000 then 6'b000111, with load_valid held and sout_ready=1 -> 12 consecutive valid cycles 1,1,1,0,0,0,0,0,0,1,1,1. load_ready=1 in cycle 6, and sout_first is in cycle 7.
- Backpressure: D=6'b101101, sout_ready=0 in bit cycles 3 and 4 -> sout holds 1 for 3 cycles, the frame finishes 2 cycles later, and the bit sequence is unchanged.
- Reset mid-frame plus load-while-busy: load_valid=1 with D=6'b010101 during bit 2 of a frame -> ignored (load_ready=0). rst asserted at bit 4 -> frame aborted with no sout_last; a next load after release starts cleanly with sout_first.
